// File: rtl/snake_pkg.sv
// Shared game constants for the snake controller and draw_snake: state and
// direction encodings plus small decode helpers.
package snake_pkg;

  typedef logic [1:0] game_state_t;
  typedef logic [2:0] dir_t;

  localparam logic [1:0] IDLE      = 2'b00;
  localparam logic [1:0] PLAY      = 2'b01;
  localparam logic [1:0] GAME_OVER = 2'b11;

  localparam logic [2:0] DIR_IDLE  = 3'b000;
  localparam logic [2:0] DIR_UP    = 3'b001;
  localparam logic [2:0] DIR_DOWN  = 3'b010;
  localparam logic [2:0] DIR_LEFT  = 3'b011;
  localparam logic [2:0] DIR_RIGHT = 3'b100;

  // Fixed priority UP > DOWN > LEFT > RIGHT; DIR_IDLE means no press.
  function automatic dir_t decode_buttons(input logic up, input logic down,
                                          input logic left, input logic right);
    if (up)    return DIR_UP;
    if (down)  return DIR_DOWN;
    if (left)  return DIR_LEFT;
    if (right) return DIR_RIGHT;
    return DIR_IDLE;
  endfunction

  function automatic dir_t opposite_dir(input dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      DIR_RIGHT: return DIR_LEFT;
      default:   return DIR_IDLE;
    endcase
  endfunction

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the game controller and its environment (buttons,
// VGA timing, draw_snake activity flags and the move outputs).
interface snake_game_ctrl_if #(
  parameter int SCORE_BITS = 8
);
  import snake_pkg::*;

  logic                  btn_up;
  logic                  btn_down;
  logic                  btn_left;
  logic                  btn_right;
  logic                  frame_tick;
  logic                  display_on;
  logic                  head_active;
  logic                  body_active;
  logic                  border_active;
  game_state_t           game_state;
  dir_t                  direction;
  logic                  update;
  logic [SCORE_BITS-1:0] score;

  // There is no back-pressure: update is a single-cycle strobe that draw_snake
  // must consume in the cycle it is high, with direction already valid.
  modport master (
    input  btn_up, btn_down, btn_left, btn_right,
    input  frame_tick, display_on, head_active, body_active, border_active,
    output game_state, direction, update, score
  );

  modport slave (
    output btn_up, btn_down, btn_left, btn_right,
    output frame_tick, display_on, head_active, body_active, border_active,
    input  game_state, direction, update, score
  );

endinterface

// File: rtl/snake_frame_div.sv
// Frame counter with synchronous clear and a terminal-count compare against a
// run-time limit, so one instance can serve several states.
module snake_frame_div #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tc = (cnt_q == last);

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: IDLE/PLAY/GAME_OVER FSM, direction latching, per-move
// update strobe, move score and frame-level collision detection.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int SPEED       = 6,
  parameter int OVER_FRAMES = 120,
  parameter int SCORE_BITS  = 8
) (
  input logic               clk,
  input logic               reset_n,
  snake_game_ctrl_if.master bus
);

  localparam int               CNT_W     = cnt_width(SPEED, OVER_FRAMES);
  localparam logic [CNT_W-1:0] PLAY_LAST = CNT_W'(SPEED - 1);
  localparam logic [CNT_W-1:0] OVER_LAST = CNT_W'(OVER_FRAMES - 1);

  game_state_t           state_q, state_d;
  dir_t                  dir_q, dir_d;
  dir_t                  pend_q, pend_d;
  dir_t                  btn_dir;
  logic                  upd_q, upd_d;
  logic                  coll_q, coll_d;
  logic                  coll_now, coll_any;
  logic [SCORE_BITS-1:0] score_q, score_d;
  logic                  cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0]      cnt_last;

  assign btn_dir  = decode_buttons(bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right);
  assign coll_now = bus.display_on && bus.head_active && (bus.body_active || bus.border_active);
  assign coll_any = coll_q || coll_now;
  assign cnt_last = (state_q == GAME_OVER) ? OVER_LAST : PLAY_LAST;

  snake_frame_div #(.W(CNT_W)) u_frame_div (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .last    (cnt_last),
    .tc      (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    upd_d   = 1'b0;
    score_d = score_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    // A hit in the tick cycle itself is evaluated before the flag clears.
    coll_d  = bus.frame_tick ? 1'b0 : coll_any;

    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        // Score survives GAME_OVER and IDLE; it only clears when a game starts.
        if (btn_dir != DIR_IDLE) begin
          dir_d   = btn_dir;
          pend_d  = btn_dir;
          score_d = '0;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (btn_dir != DIR_IDLE && btn_dir != dir_q && btn_dir != opposite_dir(dir_q)) begin
          pend_d = btn_dir;
        end
        if (bus.frame_tick) begin
          if (coll_any) begin
            state_d = GAME_OVER;
            dir_d   = DIR_IDLE;
            pend_d  = DIR_IDLE;
            cnt_clr = 1'b1;
          end else if (cnt_tc) begin
            dir_d   = pend_q;
            upd_d   = 1'b1;
            cnt_clr = 1'b1;
            if (score_q != '1) begin
              score_d = score_q + SCORE_BITS'(1);
            end
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      GAME_OVER: begin
        dir_d  = DIR_IDLE;
        pend_d = DIR_IDLE;
        if (bus.frame_tick) begin
          if (cnt_tc) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        dir_d   = DIR_IDLE;
        pend_d  = DIR_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dir_q   <= DIR_IDLE;
      pend_q  <= DIR_IDLE;
      upd_q   <= 1'b0;
      coll_q  <= 1'b0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      upd_q   <= upd_d;
      coll_q  <= coll_d;
      score_q <= score_d;
    end
  end

  assign bus.game_state = state_q;
  assign bus.direction  = dir_q;
  assign bus.update     = upd_q;
  assign bus.score      = score_q;

endmodule

// File: doc/snake_game_ctrl.md
# snake_game_ctrl

Game sequencer for the snake datapath. Owns the game-state FSM (IDLE / PLAY / GAME_OVER), the latched movement direction, the per-move `update` strobe and the move score. Watches the per-pixel head/body/border activity flags during each frame to detect collisions. Sits between the button synchroniser and VGA timing on one side and `draw_snake` on the other, driving its `update`, `direction` and `game_state` inputs.

## Interface
- `SPEED`, 6: frames per snake move (≥1).
- `OVER_FRAMES`, 120: frames GAME_OVER is held before returning to IDLE (≥1).
- `SCORE_BITS`, 8: score width.
- `clk` in 1: pixel clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each: synchronised, debounced, level buttons.
- `frame_tick` in 1: one-cycle pulse per frame, at the first cycle of vertical blank.
- `display_on` in 1: pixel is in the visible area.
- `head_active` in 1: `draw_snake` head hit at the current pixel.
- `body_active` in 1: `draw_snake` body hit at the current pixel.
- `border_active` in 1: current pixel is playfield wall.
- `game_state` out 2: 00 IDLE, 01 PLAY, 11 GAME_OVER.
- `direction` out 3: 000 IDLE, 001 UP, 010 DOWN, 011 LEFT, 100 RIGHT.
- `update` out 1: one-cycle move strobe to `draw_snake`.
- `score` out SCORE_BITS: moves survived in the current game.

## Operation
- Reset values: `game_state` = IDLE, `direction` = IDLE, `pending_dir` = IDLE, `update` = 0, `score` = 0, frame counter = 0, collision flag = 0.
- Button decode priority is UP > DOWN > LEFT > RIGHT. When no button is pressed, the decoded value is none.
- IDLE:
  - A decoded button loads `direction` and `pending_dir` with that value.
  - The FSM moves to PLAY on the next edge.
  - `score` and the frame counter clear.
- PLAY:
  - Each cycle, a decoded button that is neither the opposite of `direction` nor equal to it loads `pending_dir`.
  - The last accepted press before a commit wins.
- Collision flag:
  - Set in any cycle where `display_on && head_active && (body_active || border_active)`.
  - Cleared on every `frame_tick` after evaluation.
- On `frame_tick` in PLAY, rules are applied in this order:
  - If the collision flag is set (including a set in the same cycle), go to GAME_OVER. No update is issued and the frame counter clears.
  - Otherwise, if frame counter == SPEED−1: `direction` ← `pending_dir`, frame counter ← 0, `update` asserted the following cycle, and `score` increments (saturating at all-ones) together with `update`.
  - Otherwise the frame counter increments.
- GAME_OVER:
  - Buttons are ignored and `direction` is forced to IDLE.
  - The frame counter counts `frame_tick`s. When count == OVER_FRAMES−1 at a tick, go to IDLE.
  - `score` holds its value until the next game starts.
- Game state encoding 10 is unreachable. If it is ever decoded, go to IDLE.

## Timing
- `update` is high for exactly one cycle: the cycle after the qualifying `frame_tick`.
- `direction` is stable from that `frame_tick` edge onward, so it is valid during the `update` cycle.
- Button-to-PLAY latency in IDLE is 1 cycle.
- The first move occurs on the SPEED-th `frame_tick` after entering PLAY.
- Collision detection to GAME_OVER happens at the next `frame_tick` edge, so the worst case is 1 frame.
- Counter width is `$clog2(max(SPEED, OVER_FRAMES))`. It never wraps within a state.
- Asynchronous reset mid-frame or mid-update forces all reset values immediately. A pending `update` is dropped.

## Structure
- Shared package `snake_pkg`: the state localparams IDLE/PLAY/GAME_OVER and the direction localparams, reused by `draw_snake`.
- One sub-module, `snake_frame_div`: frame counter with a clear input and a terminal-count output, parameterised by width. It is instantiated once and shared by the PLAY and GAME_OVER counting.

## Test plan
- Reset, then press `btn_right` for 1 cycle:
  - `game_state` = 01 and `direction` = 100 one cycle later.
  - With SPEED=6, `update` pulses one cycle after the 6th `frame_tick`.
  - `score` = 1.
- In PLAY moving RIGHT, press `btn_left`, then `btn_up` in the same frame:
  - The reversal is ignored.
  - `direction` = 001 at the next commit tick.
- Assert `head_active` and `border_active` together with `display_on` for one cycle:
  - At the next `frame_tick`, `game_state` = 11, `update` stays 0 and `direction` = 000.
- Assert `head_active` and `body_active` on the same cycle as a commit `frame_tick`:
  - The FSM goes to GAME_OVER and no `update` pulse is issued.
- In GAME_OVER with OVER_FRAMES=3, hold buttons pressed:
  - State stays 11 for 2 ticks and becomes 00 at the 3rd.
  - `score` is retained, then clears on the next start.
- Drop `reset_n` for 1 cycle while an `update` is pending:
  - All outputs go to their reset values asynchronously and no `update` follows.
